seq_recur: RTL and testbench
============================

Name: seq_recur

Overview:
- Clocked, parametrised successor to the self-timed Fibonacci calculator.
- Computes term N of a second-order additive recurrence x(n)=x(n-1)+x(n-2) with programmable seeds, so Fibonacci, Lucas or any user seed pair is supported.
- Optional modular reduction, sticky overflow detection, and any N >= 0 (no N >= 3 restriction).
- Keeps the req/fin four-phase handshake so it drops into existing handshake-driven datapaths.

Parameters:
- W, 32, data width of seeds, modulus and result.
- NW, 16, width of term index N and the internal iteration counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  level request, four-phase.
- n  in  NW  term index, sampled at start.
- s0  in  W  seed x(0), sampled at start.
- s1  in  W  seed x(1), sampled at start.
- m  in  W  modulus, sampled at start; 0 = no reduction (wrap mod 2^W).
- fin  out  1  result valid / handshake acknowledge.
- busy  out  1  computation in progress.
- result  out  W  x(n), or x(n) mod m.
- ovf  out  1  sticky: an unreduced sum carried out of W bits during this run.
- err  out  1  mod mode with s0 >= m or s1 >= m.

Behaviour:
- Reset (async, immediate): state=IDLE; fin=0, busy=0, result=0, ovf=0, err=0; internal a, b, i = 0.
- States: IDLE, CALC, DONE.
- IDLE, req=1 sampled at edge e0:
  - latch n, m; clear ovf/err; a<=s0, b<=s1, i<=1.
  - n==0: result<=s0, go DONE.
  - mod mode (m!=0) and (s0>=m or s1>=m): err<=1, result<=0, go DONE.
  - otherwise go CALC with busy=1.
- CALC, each edge e_k (k>=1):
  - i==n: result<=b, busy<=0, go DONE.
  - else: a<=b; b<=next(a,b); i<=i+1.
- Latency: fin rises after edge e_n for n>=1, after e0 for n==0 or err. Iteration count is exactly n edges.
- next(a,b), mod mode: sum computed W+1 bits; if sum>=m then sum-m, else sum. Never sets ovf.
- next(a,b), m==0: low W bits of a+b; carry-out sets ovf, sticky until the next start.
- DONE: fin=1; result/ovf/err held stable. When req is sampled 0: fin<=0, go IDLE. result/ovf/err hold until the next start.
- Abort: req sampled 0 while in CALC -> go IDLE, busy<=0, fin stays 0, result unchanged.
- A new run requires req to be seen 0 in IDLE first (no re-trigger while req is held high after DONE).
- Input changes on n/s0/s1/m after e0 are ignored until the next start.
- i never wraps: n <= 2^NW-1 and i counts 1..n.
- busy and fin are never both 1.

Decomposition:
- Shared package seq_recur_pkg: state enum (IDLE, CALC, DONE).
- Natural sub-module: mod_add (W-wide add with carry-out and conditional subtract of m; combinational). Outputs sum and carry.
- FSM, counter and registers stay in seq_recur.

Test Plan:
- W=32, s0=0, s1=1, m=0, n=10, req high -> fin high exactly 10 edges after e0, result=55, ovf=0, err=0; req low -> fin low next edge.
- Lucas: s0=2, s1=1, n=5 -> result=11, latency 5 edges; n=0 -> result=2 after e0; n=1 -> result=1 after e1.
- W=8, s0=0, s1=1, m=0: n=13 -> 233, ovf=0; n=14 -> result=121, ovf=1, held through DONE.
- Mod: s0=0, s1=1, m=7, n=10 -> result=6, ovf=0. s0=9, m=7 -> err=1, result=0, fin after e0.
- Abort: n=100, req dropped at edge e20 -> busy=0, fin never rises, result unchanged. New req -> correct fresh result.
- Async reset mid-CALC (n=50, reset asserted between edges) -> fin/busy/result/ovf/err=0 immediately. After release, held-high req starts a run only once IDLE samples req=1.

Source files
------------

// File: rtl/seq_recur_pkg.sv
// Shared types for the seq_recur recurrence engine.
package seq_recur_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_recur_mod_add.sv
// One recurrence step: W-bit add with carry-out, optionally reduced modulo m.
module seq_recur_mod_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] raw;
  logic [W:0] mExt;

  // Both operands are already below m in mod mode, so one subtraction is enough.
  always_comb begin
    raw   = {1'b0, a} + {1'b0, b};
    mExt  = {1'b0, m};
    carry = raw[W];
    if ((m != '0) && (raw >= mExt)) begin
      sum = W'(raw - mExt);
    end else begin
      sum = raw[W-1:0];
    end
  end

endmodule

// File: rtl/seq_recur.sv
// Clocked second-order additive recurrence x(n)=x(n-1)+x(n-2) with
// programmable seeds, optional modulus and a four-phase req/fin handshake.
module seq_recur
  import seq_recur_pkg::*;
#(
  parameter int W  = 32,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [NW-1:0] n,
  input  logic [W-1:0]  s0,
  input  logic [W-1:0]  s1,
  input  logic [W-1:0]  m,
  output logic          fin,
  output logic          busy,
  output logic [W-1:0]  result,
  output logic          ovf,
  output logic          err
);

  state_t        stateReg, stateNext;
  logic [W-1:0]  aReg, aNext;
  logic [W-1:0]  bReg, bNext;
  logic [W-1:0]  mReg, mNext;
  logic [W-1:0]  resultReg, resultNext;
  logic [NW-1:0] iReg, iNext;
  logic [NW-1:0] nReg, nNext;
  logic          ovfReg, ovfNext;
  logic          errReg, errNext;
  logic [W-1:0]  stepSum;
  logic          stepCarry;

  seq_recur_mod_add #(.W(W)) uModAdd (
    .a     (aReg),
    .b     (bReg),
    .m     (mReg),
    .sum   (stepSum),
    .carry (stepCarry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg  <= IDLE;
      aReg      <= '0;
      bReg      <= '0;
      mReg      <= '0;
      resultReg <= '0;
      iReg      <= '0;
      nReg      <= '0;
      ovfReg    <= 1'b0;
      errReg    <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      aReg      <= aNext;
      bReg      <= bNext;
      mReg      <= mNext;
      resultReg <= resultNext;
      iReg      <= iNext;
      nReg      <= nNext;
      ovfReg    <= ovfNext;
      errReg    <= errNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    aNext      = aReg;
    bNext      = bReg;
    mNext      = mReg;
    resultNext = resultReg;
    iNext      = iReg;
    nNext      = nReg;
    ovfNext    = ovfReg;
    errNext    = errReg;

    case (stateReg)
      IDLE: begin
        if (req) begin
          nNext   = n;
          mNext   = m;
          ovfNext = 1'b0;
          errNext = 1'b0;
          aNext   = s0;
          bNext   = s1;
          iNext   = NW'(1);
          if (n == '0) begin
            resultNext = s0;
            stateNext  = DONE;
          end else if ((m != '0) && ((s0 >= m) || (s1 >= m))) begin
            errNext    = 1'b1;
            resultNext = '0;
            stateNext  = DONE;
          end else begin
            stateNext = CALC;
          end
        end
      end

      CALC: begin
        // Dropping req mid-run aborts without touching the previous result.
        if (!req) begin
          stateNext = IDLE;
        end else if (iReg == nReg) begin
          resultNext = bReg;
          stateNext  = DONE;
        end else begin
          aNext = bReg;
          bNext = stepSum;
          iNext = iReg + NW'(1);
          if ((mReg == '0) && stepCarry) begin
            ovfNext = 1'b1;
          end
        end
      end

      DONE: begin
        if (!req) begin
          stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  assign busy   = (stateReg == CALC);
  assign fin    = (stateReg == DONE);
  assign result = resultReg;
  assign ovf    = ovfReg;
  assign err    = errReg;

endmodule

// File: tb/tb_seq_recur.sv
// Randomised and directed bench for seq_recur, using a 32-bit and an 8-bit instance.
module tb_seq_recur;

  logic        clk = 1'b0;
  logic        rst;
  logic        req32, req8;
  logic [15:0] n;
  logic [31:0] s0, s1, m;

  logic        fin32, busy32, ovf32, err32;
  logic [31:0] res32;
  logic        fin8, busy8, ovf8, err8;
  logic [7:0]  res8;

  logic        sel8;
  logic        finS, busyS, ovfS, errS;
  logic [31:0] resS;

  int checks = 0;
  int errors = 0;
  longint unsigned lastRes32 = 0;

  always #5 clk = ~clk;

  seq_recur #(.W(32), .NW(16)) dut32 (
    .clk(clk), .rst(rst), .req(req32), .n(n), .s0(s0), .s1(s1), .m(m),
    .fin(fin32), .busy(busy32), .result(res32), .ovf(ovf32), .err(err32)
  );

  seq_recur #(.W(8), .NW(16)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .n(n), .s0(s0[7:0]), .s1(s1[7:0]), .m(m[7:0]),
    .fin(fin8), .busy(busy8), .result(res8), .ovf(ovf8), .err(err8)
  );

  assign finS  = sel8 ? fin8  : fin32;
  assign busyS = sel8 ? busy8 : busy32;
  assign ovfS  = sel8 ? ovf8  : ovf32;
  assign errS  = sel8 ? err8  : err32;
  assign resS  = sel8 ? {24'd0, res8} : res32;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain iterated arithmetic over the term sequence.
  function automatic void model(input int w, input int unsigned nn,
                                input longint unsigned a0In, input longint unsigned a1In,
                                input longint unsigned mIn,
                                output longint unsigned res, output bit ov,
                                output bit er, output int lat);
    longint unsigned mask, a0, a1, mm, x0, x1, s;
    mask = (64'd1 << w) - 1;
    a0 = a0In & mask;
    a1 = a1In & mask;
    mm = mIn & mask;
    ov = 0;
    er = 0;
    if (nn == 0) begin
      res = a0;
      lat = 1;
    end else if (mm != 0 && (a0 >= mm || a1 >= mm)) begin
      er  = 1;
      res = 0;
      lat = 1;
    end else begin
      x0 = a0;
      x1 = a1;
      for (int k = 2; k <= int'(nn); k++) begin
        s = x0 + x1;
        if (mm == 0) begin
          if (s > mask) ov = 1;
          s = s & mask;
        end else begin
          s = s % mm;
        end
        x0 = x1;
        x1 = s;
      end
      res = x1;
      lat = int'(nn) + 1;
    end
  endfunction

  task automatic setReq(input bit use8, input logic v);
    if (use8) req8 = v;
    else req32 = v;
  endtask

  task automatic runOp(input string tag, input bit use8, input int unsigned nn,
                       input longint unsigned a0, input longint unsigned a1,
                       input longint unsigned mm);
    longint unsigned expRes;
    bit expOvf, expErr;
    int lat, cnt;
    model(use8 ? 8 : 32, nn, a0, a1, mm, expRes, expOvf, expErr, lat);
    @(negedge clk);
    sel8 = use8;
    n  = 16'(nn);
    s0 = 32'(a0);
    s1 = 32'(a1);
    m  = 32'(mm);
    setReq(use8, 1'b1);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 1) begin
        // Post-start input changes must be ignored.
        n = 16'($urandom);
        s0 = $urandom;
        s1 = $urandom;
        m = $urandom;
        if (lat > 1) check({tag, ".busy"}, busyS, 1);
      end
    end while (!finS && cnt <= lat + 5);
    check({tag, ".latency"}, cnt, lat);
    check({tag, ".result"}, resS, expRes);
    check({tag, ".ovf"}, ovfS, expOvf);
    check({tag, ".err"}, errS, expErr);
    repeat (2) @(posedge clk);
    #1;
    check({tag, ".hold"}, {finS, resS}, {1'b1, 32'(expRes)});
    setReq(use8, 1'b0);
    @(posedge clk);
    #1;
    check({tag, ".finDrop"}, finS, 0);
    check({tag, ".resKeep"}, resS, expRes);
    $display("run %s w=%0d n=%0d s0=%0d s1=%0d m=%0d -> result=%0d ovf=%0d err=%0d lat=%0d",
             tag, use8 ? 8 : 32, nn, a0, a1, mm, resS, ovfS, errS, cnt);
    if (!use8) lastRes32 = expRes;
  endtask

  always @(negedge clk) begin
    if (!rst) check("busyFinExclusive", {busy32 & fin32, busy8 & fin8}, 0);
  end

  initial begin
    longint unsigned expRes;
    bit expOvf, expErr;
    int lat, cnt;
    longint unsigned ra0, ra1, rm;

    rst = 1'b1;
    req32 = 1'b0;
    req8 = 1'b0;
    sel8 = 1'b0;
    n = '0; s0 = '0; s1 = '0; m = '0;
    #2;
    check("reset32", {fin32, busy32, res32, ovf32, err32}, 0);
    check("reset8", {fin8, busy8, res8, ovf8, err8}, 0);
    #20 rst = 1'b0;

    runOp("fib10", 0, 10, 0, 1, 0);
    check("fib10.const", lastRes32, 55);
    runOp("lucas5", 0, 5, 2, 1, 0);
    runOp("lucas0", 0, 0, 2, 1, 0);
    runOp("lucas1", 0, 1, 2, 1, 0);
    runOp("mod7", 0, 10, 0, 1, 7);
    runOp("modErr", 0, 10, 9, 1, 7);
    runOp("w8n13", 1, 13, 0, 1, 0);
    runOp("w8n14", 1, 14, 0, 1, 0);

    // Abort mid-run: req seen low at e20.
    runOp("preAbort", 0, 12, 3, 4, 0);
    @(negedge clk);
    sel8 = 0;
    n = 16'd100; s0 = 0; s1 = 1; m = 0;
    req32 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort.busyBefore", busy32, 1);
    req32 = 1'b0;
    @(posedge clk);
    #1;
    check("abort.busy", busy32, 0);
    check("abort.result", res32, lastRes32);
    repeat (3) @(posedge clk);
    #1;
    check("abort.noFin", fin32, 0);
    runOp("postAbort", 0, 20, 0, 1, 0);

    // Async reset mid-run with req held high throughout.
    model(32, 50, 0, 1, 0, expRes, expOvf, expErr, lat);
    @(negedge clk);
    n = 16'd50; s0 = 0; s1 = 1; m = 0;
    req32 = 1'b1;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("asyncRst", {fin32, busy32, res32, ovf32, err32}, 0);
    #2 rst = 1'b0;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!fin32 && cnt <= lat + 5);
    check("rstRun.latency", cnt, lat);
    check("rstRun.result", res32, expRes);
    check("rstRun.ovf", ovf32, expOvf);
    $display("run rstRun n=50 -> result=%0d ovf=%0d lat=%0d", res32, ovf32, cnt);
    req32 = 1'b0;
    @(posedge clk);
    #1;
    check("rstRun.finDrop", fin32, 0);
    lastRes32 = expRes;

    for (int t = 0; t < 40; t++) begin
      bit use8 = t[0];
      ra0 = $urandom;
      ra1 = $urandom;
      case ($urandom_range(0, 2))
        0: rm = 0;
        1: rm = $urandom_range(1, 200);
        default: rm = $urandom;
      endcase
      if (use8) rm = rm & 8'hff;
      if (rm != 0 && $urandom_range(0, 3) != 0) begin
        ra0 = ra0 % rm;
        ra1 = ra1 % rm;
      end
      runOp($sformatf("rand%0d", t), use8, $urandom_range(0, 40), ra0, ra1, rm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
